// File: rtl/video_sync_decoder.sv
// Receive-side decoder for the Centipede video timing strobes: recovers active-pixel coordinates,
// data enable, line/frame length measurements and a frame-lock indication.
module video_sync_decoder #(
  parameter int HCNT_W      = 9,
  parameter int VCNT_W      = 8,
  parameter int FL_W        = 9,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              pix_en,
  input  logic              hsync_n,
  input  logic              vsync_n,
  input  logic              hblank_n,
  input  logic              vblank_n,
  output logic [HCNT_W-1:0] x,
  output logic [VCNT_W-1:0] y,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic [HCNT_W-1:0] line_len,
  output logic [FL_W-1:0]   frame_lines,
  output logic              locked,
  output logic              sync_err
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              hb_prev_q, hb_prev_d;
  logic [HCNT_W-1:0] x_q, x_d;
  logic [VCNT_W-1:0] y_q, y_d;
  logic              de_q, de_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [HCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [HCNT_W-1:0] line_len_q, line_len_d;
  logic [FL_W-1:0]   line_cnt_q, line_cnt_d;
  logic [FL_W-1:0]   frame_lines_q, frame_lines_d;
  lock_state_e       state_q, state_d;
  logic [FL_W-1:0]   ref_len_q, ref_len_d;
  logic [MW-1:0]     match_q, match_d;
  logic              sync_err_q, sync_err_d;

  logic              hs_fall, vs_fall, hb_rise;
  logic [HCNT_W-1:0] x_inc, pix_inc;
  logic [VCNT_W-1:0] y_inc;
  logic [FL_W-1:0]   line_inc;
  logic [MW-1:0]     match_inc;

  // Edges are qualified by pix_en so every consumer sees them only in enabled samples.
  assign hs_fall = pix_en & hs_prev_q & ~hsync_n;
  assign vs_fall = pix_en & vs_prev_q & ~vsync_n;
  assign hb_rise = pix_en & ~hb_prev_q & hblank_n;

  assign x_inc     = (x_q == '1)        ? x_q        : x_q + HCNT_W'(1);
  assign y_inc     = (y_q == '1)        ? y_q        : y_q + VCNT_W'(1);
  assign pix_inc   = (pix_cnt_q == '1)  ? pix_cnt_q  : pix_cnt_q + HCNT_W'(1);
  assign line_inc  = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + FL_W'(1);
  assign match_inc = match_q + MW'(1);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hb_prev_d     = hb_prev_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    line_len_d    = line_len_q;
    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;

    if (pix_en) begin
      hs_prev_d     = hsync_n;
      vs_prev_d     = vsync_n;
      hb_prev_d     = hblank_n;
      de_d          = hblank_n & vblank_n;
      line_start_d  = hs_fall;
      frame_start_d = vs_fall;

      if (hb_rise) begin
        x_d = '0;
      end else if (hblank_n) begin
        x_d = x_inc;
      end

      // A simultaneous vsync fall overrides the line increment.
      if (vs_fall) begin
        y_d = '0;
      end else if (hs_fall) begin
        y_d = y_inc;
      end

      if (hs_fall) begin
        line_len_d = pix_inc;
        pix_cnt_d  = '0;
        line_cnt_d = line_inc;
      end else begin
        pix_cnt_d  = pix_inc;
      end

      if (vs_fall) begin
        frame_lines_d = hs_fall ? line_inc : line_cnt_q;
        line_cnt_d    = '0;
      end
    end
  end

  // Lock FSM: judged on each frame length captured at a vsync fall.
  always_comb begin
    state_d    = state_q;
    ref_len_d  = ref_len_q;
    match_d    = match_q;
    sync_err_d = 1'b0;

    if (vs_fall) begin
      case (state_q)
        SEARCH: begin
          state_d   = CHECK;
          ref_len_d = frame_lines_d;
          match_d   = '0;
        end
        CHECK: begin
          ref_len_d = frame_lines_d;
          if (frame_lines_d == ref_len_q) begin
            match_d = match_inc;
            if (match_inc == MW'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (frame_lines_d != ref_len_q) begin
            state_d    = SEARCH;
            match_d    = '0;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (state_q == LOCKED && pix_en && line_cnt_d == '1) begin
      // Line counter pinned at its ceiling means vsync has gone missing.
      state_d    = SEARCH;
      match_d    = '0;
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      hb_prev_q     <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_cnt_q     <= '0;
      line_len_q    <= '0;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      state_q       <= SEARCH;
      ref_len_q     <= '0;
      match_q       <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hb_prev_q     <= hb_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_cnt_q     <= pix_cnt_d;
      line_len_q    <= line_len_d;
      line_cnt_q    <= line_cnt_d;
      frame_lines_q <= frame_lines_d;
      state_q       <= state_d;
      ref_len_q     <= ref_len_d;
      match_q       <= match_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Self-checking bench for video_sync_decoder: hand-computed vector table, then synthetic frames
// with randomized pix_en gaps compared every clock against a sample-indexed reference model.
module tb_video_sync_decoder;

  localparam int HCNT_W = 9;
  localparam int VCNT_W = 8;
  localparam int FL_W   = 9;
  localparam int LOCK_FRAMES = 2;
  localparam int XMAX = 511;
  localparam int YMAX = 255;
  localparam int LMAX = 511;
  localparam int FMAX = 511;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  logic pix_en = 1'b0;
  logic hsync_n = 1'b1, vsync_n = 1'b1, hblank_n = 1'b0, vblank_n = 1'b0;
  logic [HCNT_W-1:0] x, line_len;
  logic [VCNT_W-1:0] y;
  logic [FL_W-1:0]   frame_lines;
  logic de, line_start, frame_start, locked, sync_err;

  video_sync_decoder #(
    .HCNT_W(HCNT_W), .VCNT_W(VCNT_W), .FL_W(FL_W), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_l(rst_l), .pix_en(pix_en),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .hblank_n(hblank_n), .vblank_n(vblank_n),
    .x(x), .y(y), .de(de), .line_start(line_start), .frame_start(frame_start),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (indexed by enabled-sample number) ----------------
  bit m_phs, m_pvs, m_phb;
  int m_idx, m_last_hs, m_lines, mx, my;
  bit m_locked;
  int m_lock_val;
  int hist[$];
  int e_de, e_ls, e_fs, e_ll, e_fl, e_se;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_phs = 1; m_pvs = 1; m_phb = 1;
    m_idx = 0; m_last_hs = -1; m_lines = 0; mx = 0; my = 0;
    m_locked = 0; m_lock_val = 0; hist.delete();
    e_de = 0; e_ls = 0; e_fs = 0; e_ll = 0; e_fl = 0; e_se = 0;
  endfunction

  function automatic void model_idle();
    e_ls = 0; e_fs = 0; e_se = 0;
  endfunction

  function automatic void model_sample(input bit hs, input bit vs, input bit hb, input bit vb);
    bit hf, vf, hr;
    int run, cap;
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    hr = !m_phb && hb;
    e_ls = int'(hf); e_fs = int'(vf); e_se = 0;
    e_de = int'(hb && vb);
    if (hr) mx = 0;
    else if (hb) mx = imin(mx + 1, XMAX);
    if (vf) my = 0;
    else if (hf) my = imin(my + 1, YMAX);
    if (hf) begin
      e_ll = imin(m_idx - m_last_hs, LMAX);
      m_last_hs = m_idx;
      m_lines++;
    end
    if (vf) begin
      cap = imin(m_lines, FMAX);
      e_fl = cap;
      m_lines = 0;
      if (m_locked) begin
        if (cap != m_lock_val) begin
          m_locked = 0; e_se = 1; hist.delete();
        end
      end else begin
        hist.push_back(cap);
        run = 1;
        for (int i = hist.size() - 1; i > 0; i--) begin
          if (hist[i-1] == hist[i]) run++;
          else break;
        end
        if (run >= LOCK_FRAMES + 1) begin
          m_locked = 1; m_lock_val = cap; hist.delete();
        end
      end
    end else if (m_locked && m_lines >= FMAX) begin
      m_locked = 0; e_se = 1; hist.delete();
    end
    m_idx++;
    m_phs = hs; m_pvs = vs; m_phb = hb;
  endfunction

  task automatic check_all();
    check("x", 64'(x), 64'(mx));
    check("y", 64'(y), 64'(my));
    check("de", 64'(de), 64'(e_de));
    check("line_start", 64'(line_start), 64'(e_ls));
    check("frame_start", 64'(frame_start), 64'(e_fs));
    check("line_len", 64'(line_len), 64'(e_ll));
    check("frame_lines", 64'(frame_lines), 64'(e_fl));
    check("locked", 64'(locked), 64'(m_locked));
    check("sync_err", 64'(sync_err), 64'(e_se));
  endtask

  // ---------------- pulse-width monitor ----------------
  int run_ls = 0, run_fs = 0, run_se = 0, max_run = 0, se_count = 0;
  always @(negedge clk) begin
    run_ls = line_start  ? run_ls + 1 : 0;
    run_fs = frame_start ? run_fs + 1 : 0;
    run_se = sync_err    ? run_se + 1 : 0;
    if (run_ls > max_run) max_run = run_ls;
    if (run_fs > max_run) max_run = run_fs;
    if (run_se > max_run) max_run = run_se;
    if (sync_err) se_count++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit rb();
    return 1'($urandom & 1);
  endfunction

  task automatic clk_cycle(input bit pe, input bit hs, input bit vs, input bit hb, input bit vb);
    pix_en = pe; hsync_n = hs; vsync_n = vs; hblank_n = hb; vblank_n = vb;
    @(posedge clk);
    #1;
    if (pe) model_sample(hs, vs, hb, vb);
    else model_idle();
    check_all();
  endtask

  task automatic do_sample(input bit hs, input bit vs, input bit hb, input bit vb);
    if (rb()) clk_cycle(1'b0, rb(), rb(), rb(), rb());
    clk_cycle(1'b1, hs, vs, hb, vb);
  endtask

  // Line layout: hsync low for 2 samples, blank 4 samples, then `act` active pixels.
  task automatic run_line(input int li, input int len, input int act, input bit vs_en,
                          input int pause_at);
    bit hs, vs, hb, vb;
    for (int s = 0; s < len; s++) begin
      if (s == pause_at) begin
        for (int k = 0; k < 50; k++) clk_cycle(1'b0, rb(), rb(), rb(), rb());
      end
      hs = (s >= 2);
      vs = !(vs_en && li < 3);
      hb = (s >= 4 && s < 4 + act);
      vb = (li >= 16 && li < 256);
      do_sample(hs, vs, hb, vb);
      if (vs_en && li == 0 && s == 0) begin
        check("coincident_y", 64'(y), 64'd0);
        check("coincident_line_start", 64'(line_start), 64'd1);
        check("coincident_frame_start", 64'(frame_start), 64'd1);
      end
    end
  endtask

  task automatic run_frame(input int nlines);
    for (int li = 0; li < nlines; li++) run_line(li, 12, 8, 1'b1, -1);
  endtask

  task automatic reset_with_toggle(input int n);
    rst_l = 1'b0;
    #1;
    check("reset_async", {x, y, de, line_start, frame_start, line_len, frame_lines, locked, sync_err},
          64'd0);
    for (int i = 0; i < n; i++) begin
      pix_en = rb(); hsync_n = rb(); vsync_n = rb(); hblank_n = rb(); vblank_n = rb();
      @(posedge clk);
      #1;
      check("reset_hold", {x, y, de, line_start, frame_start, line_len, frame_lines, locked, sync_err},
            64'd0);
    end
    pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; hblank_n = 1'b0; vblank_n = 1'b0;
    rst_l = 1'b1;
    model_reset();
  endtask

  // ---------------- hand-computed vector table ----------------
  typedef struct {
    bit pe, hs, vs, hb, vb;
    int ex, ey, ede, els, efs, ell, efl;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //           pe hs vs hb vb   x  y de ls fs ll fl
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 0, 1, 0, 2, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 0, 0, 0, 2, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 0, 2, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1, 0, 0, 0, 2, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 0, 1, 1, 4, 2};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 0, 4, 2};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 0, 1, 0, 2, 2};

    #2;
    reset_with_toggle(4);

    for (int i = 0; i < 10; i++) begin
      pix_en = tbl[i].pe; hsync_n = tbl[i].hs; vsync_n = tbl[i].vs;
      hblank_n = tbl[i].hb; vblank_n = tbl[i].vb;
      @(posedge clk);
      #1;
      check("tbl_x", 64'(x), 64'(tbl[i].ex));
      check("tbl_y", 64'(y), 64'(tbl[i].ey));
      check("tbl_de", 64'(de), 64'(tbl[i].ede));
      check("tbl_line_start", 64'(line_start), 64'(tbl[i].els));
      check("tbl_frame_start", 64'(frame_start), 64'(tbl[i].efs));
      check("tbl_line_len", 64'(line_len), 64'(tbl[i].ell));
      check("tbl_frame_lines", 64'(frame_lines), 64'(tbl[i].efl));
      check("tbl_locked", 64'(locked), 64'd0);
    end

    // Reset from the mid-sequence state above.
    reset_with_toggle(6);
    for (int i = 0; i < 4; i++) clk_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Wide line: 384 samples with 256 active pixels, entered mid-frame.
    run_line(100, 384, 256, 1'b1, -1);
    check("x_end_of_wide_line", 64'(x), 64'd255);
    run_line(101, 12, 8, 1'b1, -1);
    check("line_len_wide", 64'(line_len), 64'd384);
    for (int li = 102; li < 262; li++) run_line(li, 12, 8, 1'b1, (li == 150) ? 6 : -1);

    for (int f = 0; f < 3; f++) run_frame(262);
    check("locked_before_4th_vsync", 64'(locked), 64'd0);
    run_frame(262);
    check("locked_after_4th_vsync", 64'(locked), 64'd1);
    check("frame_lines_262", 64'(frame_lines), 64'd262);
    check("line_len_12", 64'(line_len), 64'd12);

    // One long frame breaks lock, then lock is re-acquired from SEARCH.
    run_frame(263);
    run_frame(262);
    check("sync_err_on_len_change", 64'(se_count), 64'd1);
    check("unlocked_after_len_change", 64'(locked), 64'd0);
    for (int f = 0; f < 3; f++) run_frame(262);
    check("relocked", 64'(locked), 64'd1);

    // vsync disappears: line counter runs to its ceiling and lock drops.
    for (int li = 1; li <= 520; li++) run_line(li, 12, 8, 1'b0, -1);
    check("sync_err_on_lost_vsync", 64'(se_count), 64'd2);
    check("unlocked_after_lost_vsync", 64'(locked), 64'd0);
    run_line(0, 12, 8, 1'b1, -1);
    check("frame_lines_saturated", 64'(frame_lines), 64'd511);

    check("max_pulse_width", 64'(max_run), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
